// File: rtl/ex_stage_if.sv
// ============================================================================
// ex_stage_if : ID/EX inputs and EX/MEM outputs of the execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface ex_stage_if;
  logic        id_valid;
  logic        mem_read_n;
  logic        mem_write_n;
  logic        mem_to_reg_n;
  logic        jumpl_n;
  logic        branch_n;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  alu_select;
  logic [31:0] PC_n2;
  logic [31:0] rs2data;
  logic [31:0] instr_n;
  logic        mem_stall;

  logic        ex_stall;
  logic        exm_valid;
  logic [31:0] exm_alu_result;
  logic [31:0] exm_rs2data;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic        exm_mem_read;
  logic        exm_mem_write;
  logic        exm_mem_to_reg;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output id_valid, mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_n,
    output A, B, alu_select, PC_n2, rs2data, instr_n, mem_stall,
    input  ex_stall, exm_valid, exm_alu_result, exm_rs2data, exm_rd,
    input  exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  id_valid, mem_read_n, mem_write_n, mem_to_reg_n, jumpl_n, branch_n,
    input  A, B, alu_select, PC_n2, rs2data, instr_n, mem_stall,
    output ex_stall, exm_valid, exm_alu_result, exm_rs2data, exm_rd,
    output exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg,
    output redirect_valid, redirect_pc
  );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// ex_stage : RV32 execute stage - ALU, branch/jump resolution, iterative MUL
// Rev 1.0
// ============================================================================
`default_nettype none

module ex_stage #(
  parameter int MUL_STEP = 4
) (
  input  logic       clk,
  input  logic       reset,
  ex_stage_if.slave  ex
);

  localparam int         N    = 32 / MUL_STEP;
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;

  logic [31:0] alu_res;
  logic [31:0] step_sum;
  logic [31:0] acc_next;
  logic [31:0] result;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [4:0]  shamt;
  logic [2:0]  funct3;
  logic        issue;
  logic        last_step;
  logic        mul_busy;
  logic        taken;
  logic        do_redirect;
  logic        reg_write;
  logic        unused_instr;

  assign shamt  = ex.B[4:0];
  assign funct3 = ex.instr_n[14:12];
  assign unused_instr = ^{ex.instr_n[24:15], ex.instr_n[6:0]};

  always_comb begin
    alu_res = ex.B;
    case (ex.alu_select)
      4'd0:    alu_res = ex.A + ex.B;
      4'd1:    alu_res = ex.A - ex.B;
      4'd2:    alu_res = ex.A & ex.B;
      4'd3:    alu_res = ex.A | ex.B;
      4'd4:    alu_res = ex.A ^ ex.B;
      4'd5:    alu_res = ex.A << shamt;
      4'd6:    alu_res = ex.A >> shamt;
      4'd7:    alu_res = $unsigned($signed(ex.A) >>> shamt);
      4'd8:    alu_res = {31'b0, $signed(ex.A) < $signed(ex.B)};
      4'd9:    alu_res = {31'b0, ex.A < ex.B};
      default: alu_res = ex.B;
    endcase
  end

  // Multiplicand walks left and multiplier walks right, MUL_STEP bits per cycle
  always_comb begin
    step_sum = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier[j]) step_sum = step_sum + (mcand << j);
    end
  end

  assign acc_next  = acc + step_sum;
  assign issue     = (state == IDLE) && ex.id_valid && (ex.alu_select == 4'd10);
  assign last_step = (state == MUL) && (cnt == LAST);
  assign mul_busy  = issue || ((state == MUL) && (cnt != LAST));
  assign ex.ex_stall = ex.mem_stall | mul_busy;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = (ex.A == ex.rs2data);
      3'b001:  taken = (ex.A != ex.rs2data);
      3'b100:  taken = ($signed(ex.A) < $signed(ex.rs2data));
      3'b101:  taken = ($signed(ex.A) >= $signed(ex.rs2data));
      3'b110:  taken = (ex.A < ex.rs2data);
      3'b111:  taken = (ex.A >= ex.rs2data);
      default: taken = 1'b0;
    endcase
  end

  assign br_target  = ex.PC_n2 + {{19{ex.instr_n[31]}}, ex.instr_n[31], ex.instr_n[7],
                                  ex.instr_n[30:25], ex.instr_n[11:8], 1'b0};
  assign jmp_target = (ex.A + ex.B) & ~32'd1;

  assign result = ex.jumpl_n ? (ex.PC_n2 + 32'd4) :
                  last_step  ? acc_next : alu_res;

  assign do_redirect = ex.id_valid && (ex.jumpl_n || (ex.branch_n && taken));
  assign reg_write   = ex.id_valid && !ex.branch_n && !ex.mem_write_n &&
                       (ex.instr_n[11:7] != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      acc               <= '0;
      mcand             <= '0;
      mplier            <= '0;
      ex.exm_valid      <= 1'b0;
      ex.exm_alu_result <= '0;
      ex.exm_rs2data    <= '0;
      ex.exm_rd         <= '0;
      ex.exm_reg_write  <= 1'b0;
      ex.exm_mem_read   <= 1'b0;
      ex.exm_mem_write  <= 1'b0;
      ex.exm_mem_to_reg <= 1'b0;
      ex.redirect_valid <= 1'b0;
      ex.redirect_pc    <= '0;
    end else if (ex.mem_stall) begin
      // Everything freezes, but the redirect must not repeat
      ex.redirect_valid <= 1'b0;
    end else begin
      ex.redirect_valid <= do_redirect && !mul_busy;
      ex.redirect_pc    <= ex.jumpl_n ? jmp_target : br_target;

      ex.exm_alu_result <= result;
      ex.exm_rs2data    <= ex.rs2data;
      ex.exm_rd         <= ex.instr_n[11:7];
      ex.exm_valid      <= ex.id_valid && !mul_busy;
      ex.exm_reg_write  <= reg_write && !mul_busy;
      ex.exm_mem_read   <= ex.id_valid && ex.mem_read_n && !mul_busy;
      ex.exm_mem_write  <= ex.id_valid && ex.mem_write_n && !mul_busy;
      ex.exm_mem_to_reg <= ex.id_valid && ex.mem_to_reg_n && !mul_busy;

      case (state)
        IDLE: begin
          if (issue) begin
            mcand  <= ex.A;
            mplier <= ex.B;
            acc    <= '0;
            cnt    <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_STEP;
          mplier <= mplier >> MUL_STEP;
          if (last_step) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// tb_ex_stage : directed scoreboard bench for the execute stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_stage;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  ex_stage_if ex ();

  ex_stage #(.MUL_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ex    (ex)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] F_NONE = 5'b00000;  // {branch, jumpl, mem_read, mem_write, mem_to_reg}
  localparam logic [4:0] F_BR   = 5'b10000;
  localparam logic [4:0] F_JL   = 5'b01000;
  localparam logic [4:0] F_LD   = 5'b00101;
  localparam logic [4:0] F_ST   = 5'b00010;

  typedef struct {
    string       tag;
    logic        valid;
    logic        chk_res;
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw, mr, mw, m2r, rv;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rd);
    return {20'b0, rd, 7'h33};
  endfunction

  function automatic logic [31:0] b_ins(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic drive(input logic vld, input logic [4:0] fl, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] rs2,
                       input logic [31:0] pc, input logic [31:0] instr);
    ex.id_valid = vld;
    {ex.branch_n, ex.jumpl_n, ex.mem_read_n, ex.mem_write_n, ex.mem_to_reg_n} = fl;
    ex.alu_select = sel;
    ex.A          = a;
    ex.B          = b;
    ex.rs2data    = rs2;
    ex.PC_n2      = pc;
    ex.instr_n    = instr;
  endtask

  // Drive one instruction, count stall cycles, then check what EX/MEM produced.
  task automatic run_op(input string tag, input logic vld, input logic [4:0] fl, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic chk_res, input logic [31:0] exp_res, input logic exp_rw,
                        input logic exp_rv, input logic [31:0] exp_rpc,
                        input int exp_stall, input int ms_at, input int ms_len, input logic hold_after);
    exp_t e;
    exp_t got;
    int   stalls;
    drive(vld, fl, sel, a, b, rs2, pc, instr);
    e.tag = tag;  e.valid = vld;  e.chk_res = chk_res;  e.res = exp_res;
    e.rs2 = rs2;  e.rd = instr[11:7];  e.rw = exp_rw;
    e.mr  = vld & fl[2];  e.mw = vld & fl[1];  e.m2r = vld & fl[0];
    e.rv  = exp_rv;  e.rpc = exp_rpc;
    sb.push_back(e);

    stalls = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      ex.mem_stall = (cyc >= ms_at) && (cyc < ms_at + ms_len);
      #1;
      if (!ex.ex_stall) break;
      stalls++;
      @(negedge clk);
    end
    chk({tag, ".stall_cycles"}, 32'(stalls), 32'(exp_stall));

    @(negedge clk);
    drive(1'b0, F_NONE, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    ex.mem_stall = hold_after;
    got = sb.pop_front();
    chk1({got.tag, ".valid"}, ex.exm_valid, got.valid);
    if (got.valid) begin
      chk({got.tag, ".rs2data"}, ex.exm_rs2data, got.rs2);
      chk({got.tag, ".rd"}, {27'b0, ex.exm_rd}, {27'b0, got.rd});
    end
    if (got.chk_res) chk({got.tag, ".result"}, ex.exm_alu_result, got.res);
    chk1({got.tag, ".reg_write"}, ex.exm_reg_write, got.rw);
    chk1({got.tag, ".mem_read"}, ex.exm_mem_read, got.mr);
    chk1({got.tag, ".mem_write"}, ex.exm_mem_write, got.mw);
    chk1({got.tag, ".mem_to_reg"}, ex.exm_mem_to_reg, got.m2r);
    chk1({got.tag, ".redirect_valid"}, ex.redirect_valid, got.rv);
    if (got.rv) chk({got.tag, ".redirect_pc"}, ex.redirect_pc, got.rpc);

    @(negedge clk);
    #1;
    chk1({tag, ".next_valid"}, ex.exm_valid, hold_after & vld);
    chk1({tag, ".next_redirect"}, ex.redirect_valid, 1'b0);
    if (hold_after && chk_res) chk({tag, ".held_result"}, ex.exm_alu_result, exp_res);
    ex.mem_stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ex.mem_stall = 1'b0;
    drive(1'b0, F_NONE, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk1("reset.valid", ex.exm_valid, 1'b0);
    chk("reset.result", ex.exm_alu_result, 32'd0);
    chk1("reset.reg_write", ex.exm_reg_write, 1'b0);
    chk1("reset.redirect_valid", ex.redirect_valid, 1'b0);
    chk("reset.redirect_pc", ex.redirect_pc, 32'd0);
    chk1("reset.ex_stall", ex.ex_stall, 1'b0);
    reset = 1'b0;

    //     tag      vld   flags   sel    A             B             rs2           PC          instr              cr    result        rw    rv    rpc        st ms ml hold
    run_op("ADD",   1'b1, F_NONE, 4'd0,  32'd5,        32'd7,        32'd0,        32'd0,      r_ins(5'd3),       1'b1, 32'd12,       1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("SUB",   1'b1, F_NONE, 4'd1,  32'd5,        32'd7,        32'd0,        32'd0,      r_ins(5'd4),       1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("AND",   1'b1, F_NONE, 4'd2,  32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,      r_ins(5'd5),       1'b1, 32'h0000F000, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("OR",    1'b1, F_NONE, 4'd3,  32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,      r_ins(5'd5),       1'b1, 32'h0000FFF0, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("XOR",   1'b1, F_NONE, 4'd4,  32'h0000F0F0, 32'h0000FF00, 32'd0,        32'd0,      r_ins(5'd5),       1'b1, 32'h00000FF0, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("SLL",   1'b1, F_NONE, 4'd5,  32'd1,        32'h00000024, 32'd0,        32'd0,      r_ins(5'd6),       1'b1, 32'h00000010, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("SRL",   1'b1, F_NONE, 4'd6,  32'h80000000, 32'd4,        32'd0,        32'd0,      r_ins(5'd6),       1'b1, 32'h08000000, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("SRA",   1'b1, F_NONE, 4'd7,  32'h80000000, 32'd4,        32'd0,        32'd0,      r_ins(5'd6),       1'b1, 32'hF8000000, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("SLT",   1'b1, F_NONE, 4'd8,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,      r_ins(5'd7),       1'b1, 32'd1,        1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("SLTU",  1'b1, F_NONE, 4'd9,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,      r_ins(5'd7),       1'b1, 32'd0,        1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("PASSB", 1'b1, F_NONE, 4'd12, 32'd1,        32'hDEADBEEF, 32'd0,        32'd0,      r_ins(5'd8),       1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("STORE", 1'b1, F_ST,   4'd0,  32'h00000100, 32'd8,        32'h00000055, 32'd0,      r_ins(5'd5),       1'b1, 32'h00000108, 1'b0, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("LOAD",  1'b1, F_LD,   4'd0,  32'h00000100, 32'd4,        32'd0,        32'd0,      r_ins(5'd7),       1'b1, 32'h00000104, 1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("RD0",   1'b1, F_NONE, 4'd0,  32'd1,        32'd1,        32'd0,        32'd0,      r_ins(5'd0),       1'b1, 32'd2,        1'b0, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("BEQ_T", 1'b1, F_BR,   4'd1,  32'd3,        32'd16,       32'd3,        32'h100,    b_ins(13'd16, 3'b000), 1'b0, 32'd0,  1'b0, 1'b1, 32'h110,   0, 0, 0, 1'b1);
    run_op("BEQ_N", 1'b1, F_BR,   4'd1,  32'd3,        32'd16,       32'd4,        32'h100,    b_ins(13'd16, 3'b000), 1'b0, 32'd0,  1'b0, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("BNE_T", 1'b1, F_BR,   4'd1,  32'd3,        32'd0,        32'd4,        32'h300,    b_ins(13'h020, 3'b001), 1'b0, 32'd0, 1'b0, 1'b1, 32'h320,   0, 0, 0, 1'b0);
    run_op("BLT_T", 1'b1, F_BR,   4'd1,  32'hFFFFFFFF, 32'd0,        32'd1,        32'h200,    b_ins(13'h1FF8, 3'b100), 1'b0, 32'd0, 1'b0, 1'b1, 32'h1F8, 0, 0, 0, 1'b0);
    run_op("BLTU_N",1'b1, F_BR,   4'd1,  32'hFFFFFFFF, 32'd0,        32'd1,        32'h200,    b_ins(13'h1FF8, 3'b110), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0,   0, 0, 0, 1'b0);
    run_op("BGEU_T",1'b1, F_BR,   4'd1,  32'hFFFFFFFF, 32'd0,        32'd1,        32'h200,    b_ins(13'h040, 3'b111), 1'b0, 32'd0, 1'b0, 1'b1, 32'h240,   0, 0, 0, 1'b0);
    run_op("BF3_N", 1'b1, F_BR,   4'd1,  32'd3,        32'd0,        32'd3,        32'h200,    b_ins(13'h040, 3'b010), 1'b0, 32'd0, 1'b0, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("JALR",  1'b1, F_JL,   4'd0,  32'h00000203, 32'd0,        32'd0,        32'h40,     r_ins(5'd1),       1'b1, 32'h00000044, 1'b1, 1'b1, 32'h202,   0, 0, 0, 1'b0);
    run_op("BUBBLE",1'b0, F_JL,   4'd0,  32'h00000203, 32'd0,        32'd0,        32'h40,     r_ins(5'd1),       1'b0, 32'd0,        1'b0, 1'b0, 32'd0,     0, 0, 0, 1'b0);
    run_op("MUL1",  1'b1, F_NONE, 4'd10, 32'h00010003, 32'h00020005, 32'd0,        32'd0,      r_ins(5'd9),       1'b1, 32'h000B000F, 1'b1, 1'b0, 32'd0,     8, 0, 0, 1'b0);
    run_op("MUL2",  1'b1, F_NONE, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd0,      r_ins(5'd9),       1'b1, 32'd1,        1'b1, 1'b0, 32'd0,     8, 0, 0, 1'b0);
    run_op("MULST", 1'b1, F_NONE, 4'd10, 32'h00010003, 32'h00020005, 32'd0,        32'd0,      r_ins(5'd10),      1'b1, 32'h000B000F, 1'b1, 1'b0, 32'd0,    11, 3, 3, 1'b0);
    run_op("JALST", 1'b1, F_JL,   4'd0,  32'h00001000, 32'h00000010, 32'd0,        32'h80,     r_ins(5'd1),       1'b1, 32'h00000084, 1'b1, 1'b1, 32'h1010,  2, 0, 2, 1'b0);

    // Reset lands while the multiplier is at iteration 4
    drive(1'b1, F_NONE, 4'd10, 32'h00010003, 32'h00020005, 32'd0, 32'd0, r_ins(5'd9));
    repeat (5) @(negedge clk);
    reset = 1'b1;
    drive(1'b0, F_NONE, 4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("mulrst.ex_stall", ex.ex_stall, 1'b0);
    chk1("mulrst.valid", ex.exm_valid, 1'b0);
    chk1("mulrst.reg_write", ex.exm_reg_write, 1'b0);
    chk("mulrst.result", ex.exm_alu_result, 32'd0);
    run_op("ADD2",  1'b1, F_NONE, 4'd0,  32'd100,      32'd23,       32'd0,        32'd0,      r_ins(5'd2),       1'b1, 32'd123,      1'b1, 1'b0, 32'd0,     0, 0, 0, 1'b0);

    chk("scoreboard.empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
